// File: rtl/dist_feeder_pkg.sv
// Shared definitions for the distribution feeder: default geometry, counter
// width and the FILL/FULL state encoding.
package dist_feeder_pkg;

  localparam int DEF_DATA_WIDTH     = 18;
  localparam int DEF_NUM_INPUT_DATA = 4;
  localparam int DEF_NUM_SUB_MACROS = 4;
  localparam int GROUP_CNT_W        = 16;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } feeder_state_t;

  // Word counter must be at least one bit wide even for tiny groups.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dist_feeder.sv
// Gathers N operand words plus one select word into a group and hands the
// pair to the distribution stage through a registered valid/ready output.
module dist_feeder
  import dist_feeder_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int NUM_INPUT_DATA = DEF_NUM_INPUT_DATA,
  parameter int NUM_SUB_MACROS = DEF_NUM_SUB_MACROS
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                s_valid,
  output logic                                                s_ready,
  input  logic [DATA_WIDTH-1:0]                               s_data,
  input  logic                                                sel_valid,
  output logic                                                sel_ready,
  input  logic [4*NUM_SUB_MACROS-1:0]                         sel_data,
  input  logic                                                i_flush,
  output logic                                                o_valid,
  input  logic                                                o_ready,
  output logic                                                o_en,
  output logic [NUM_SUB_MACROS*NUM_INPUT_DATA*DATA_WIDTH-1:0] o_data_bus,
  output logic [4*NUM_SUB_MACROS-1:0]                         o_sparse_select,
  output logic [GROUP_CNT_W-1:0]                              o_group_cnt,
  output feeder_state_t                                       o_state
);

  localparam int N  = NUM_SUB_MACROS * NUM_INPUT_DATA;
  localparam int SW = 4 * NUM_SUB_MACROS;
  localparam int CW = cnt_width(N);
  localparam int BW = N * DATA_WIDTH;

  // Handshake: a transfer happens on a rising clk edge where valid && ready are
  // both high; valid never waits on ready, and a held output stays unchanged.
  feeder_state_t          state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BW-1:0]          fill_q, fill_d;
  logic                   sel_cap_q, sel_cap_d;
  logic [SW-1:0]          sel_q, sel_d;
  logic                   out_valid_q, out_valid_d;
  logic [BW-1:0]          out_data_q, out_data_d;
  logic [SW-1:0]          out_sel_q, out_sel_d;
  logic [GROUP_CNT_W-1:0] grp_cnt_q, grp_cnt_d;

  logic word_acc;
  logic sel_acc;
  logic last_word;
  logic hand_off;

  assign s_ready   = (state_q == ST_FILL);
  assign sel_ready = !sel_cap_q;
  assign word_acc  = s_valid && s_ready;
  assign sel_acc   = sel_valid && sel_ready;
  assign last_word = (cnt_q == CW'(N - 1));
  // A flush wins over a pending hand-off so the output register is untouched.
  assign hand_off  = (state_q == ST_FULL) && sel_cap_q &&
                     (!out_valid_q || o_ready) && !i_flush;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fill_d      = fill_q;
    sel_cap_d   = sel_cap_q;
    sel_d       = sel_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    grp_cnt_d   = grp_cnt_q;

    if (out_valid_q && o_ready) begin
      out_valid_d = 1'b0;
    end

    if (i_flush) begin
      state_d   = ST_FILL;
      cnt_d     = '0;
      sel_cap_d = 1'b0;
    end else begin
      if (sel_acc) begin
        sel_cap_d = 1'b1;
        sel_d     = sel_data;
      end

      case (state_q)
        ST_FILL: begin
          if (word_acc) begin
            for (int k = 0; k < N; k++) begin
              if (cnt_q == CW'(k)) begin
                fill_d[k*DATA_WIDTH +: DATA_WIDTH] = s_data;
              end
            end
            if (last_word) begin
              cnt_d   = '0;
              state_d = ST_FULL;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        ST_FULL: begin
          if (hand_off) begin
            out_data_d  = fill_q;
            out_sel_d   = sel_q;
            out_valid_d = 1'b1;
            sel_cap_d   = 1'b0;
            grp_cnt_d   = grp_cnt_q + GROUP_CNT_W'(1);
            state_d     = ST_FILL;
          end
        end
        default: state_d = ST_FILL;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_FILL;
      cnt_q       <= '0;
      fill_q      <= '0;
      sel_cap_q   <= 1'b0;
      sel_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      grp_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fill_q      <= fill_d;
      sel_cap_q   <= sel_cap_d;
      sel_q       <= sel_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      grp_cnt_q   <= grp_cnt_d;
    end
  end

  assign o_valid         = out_valid_q;
  assign o_en            = out_valid_q;
  assign o_data_bus      = out_data_q;
  assign o_sparse_select = out_sel_q;
  assign o_group_cnt     = grp_cnt_q;
  assign o_state         = state_q;

endmodule

// File: doc/dist_feeder.md
DIST_FEEDER -- requirements
Module: dist_feeder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 18, width of one clubbed activation/weight word.
REQ-002 SHALL have parameter NUM_INPUT_DATA, default 4, candidate words per sub-macro.
REQ-003 SHALL have parameter NUM_SUB_MACROS, default 4, number of sub-macros.
REQ-004 SHALL define N = NUM_SUB_MACROS*NUM_INPUT_DATA, words per group, and SW = 4*NUM_SUB_MACROS, select-word width.
REQ-005 SHALL have port clk, input, 1, the single clock.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port s_valid, input, 1, operand word valid.
REQ-008 SHALL have port s_ready, output, 1, operand word accepted.
REQ-009 SHALL have port s_data, input, DATA_WIDTH, operand word.
REQ-010 SHALL have port sel_valid, input, 1, select word valid.
REQ-011 SHALL have port sel_ready, output, 1, select word accepted.
REQ-012 SHALL have port sel_data, input, SW, two mux-row selects, 2 bits per mux.
REQ-013 SHALL have port i_flush, input, 1, synchronous discard of the partially filled group.
REQ-014 SHALL have port o_valid, output, 1, group valid toward the distribution stage.
REQ-015 SHALL have port o_ready, input, 1, downstream accepts the group.
REQ-016 SHALL have port o_en, output, 1, distribute enable, equal to o_valid.
REQ-017 SHALL have port o_data_bus, output, N*DATA_WIDTH, assembled group.
REQ-018 SHALL have port o_sparse_select, output, SW, select word paired with o_data_bus.
REQ-019 SHALL have port o_group_cnt, output, 16, count of groups handed off.

Function
REQ-020 SHALL transfer an operand word when s_valid && s_ready is high at a clk rising edge, and a select word when sel_valid && sel_ready is high.
REQ-021 SHALL write the k-th accepted word of a group (k = 0..N-1) to fill-buffer bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-022 SHALL implement a two-state FSM: FILL and FULL.
REQ-023 SHALL drive s_ready = 1 only in FILL; word counter width is clog2(N), resets to 0 on the N-th accept.
REQ-024 SHALL drive sel_ready = 1 only while no select word is captured for the current group, in either state.
REQ-025 SHALL move FILL->FULL on the edge that accepts word N-1, regardless of select-word status.
REQ-026 SHALL, in FULL, hand off once a select word is captured and (!o_valid || o_ready), in the same cycle loading the output register, setting o_valid, clearing the select-captured flag and returning to FILL.
REQ-027 SHALL make the minimum latency from acceptance of the last word (with select already captured) to o_valid exactly 2 clk edges; throughput is one group per N+1 cycles.
REQ-028 SHALL hold o_data_bus, o_sparse_select and o_valid stable while o_valid && !o_ready.
REQ-029 SHALL clear o_valid on o_ready unless a new hand-off occurs in the same cycle, in which case o_valid stays 1 with new data.
REQ-030 SHALL, on i_flush, clear the word counter and the select-captured flag and enter FILL; the output register is unaffected; an accept coincident with i_flush is discarded.
REQ-031 SHALL increment o_group_cnt on each hand-off, wrapping 0xFFFF->0x0000.
REQ-032 SHALL accept a select word for the group being filled at any point, including while FULL waits on the downstream stage.

Reset
REQ-033 SHALL, on rst, asynchronously set the state to FILL, the counter to 0, the select-captured flag to 0, o_valid/o_en to 0, o_group_cnt to 0, and o_data_bus and o_sparse_select to all-zero.
REQ-034 SHALL, on rst asserted mid-group, discard the partial group; the first accept after release is word 0.

Structure
REQ-035 SHALL place the FSM state encoding and the default-parameter constants in the shared FLOW package.
REQ-036 SHALL be a single module; no sub-module is required.

Verification
REQ-037 SHALL cover a basic group: words 0x00001..0x00010 back-to-back, sel_data=0x1B1B, o_ready=1 -> o_valid rises 2 edges after word 16; o_data_bus word k = k+1; o_sparse_select = 0x1B1B; o_group_cnt = 1.
REQ-038 SHALL cover backpressure: o_ready=0 for 5 cycles with a second group filling -> first group held stable; second group stays FULL with s_ready=0 until o_ready=1, then hands off in that cycle.
REQ-039 SHALL cover a late select: 16 words, sel_valid withheld 3 cycles -> FSM stays FULL and o_valid stays 0; o_valid is 1 on the edge after the select is accepted.
REQ-040 SHALL cover flush: i_flush after 7 words -> the next 16 words form a clean group, with word 0 equal to the first word after the flush.
REQ-041 SHALL cover reset mid-operation: rst asserted while o_valid=1 and 5 words are filled -> o_valid=0 and the bus is 0 immediately, and o_group_cnt=0.
REQ-042 SHALL cover wrap: o_group_cnt preloaded via 65536 hand-offs (or forced) -> counter reads 0x0000 after the 65536th hand-off.
